// File: rtl/ascii_operand_parser.sv
// ASCII operand parser: assembles decimal operands X then Y from a character stream for the adder.
// Latency: operands_valid rises one cycle after Y's closing Enter; parse_err is one cycle after the bad char.
// Backpressure: char_ready drops while a pair is held; pair released on operands_valid & operands_ready.
// Optional feature: define PARSER_RANGE_CHECK_EN to reject operands above MAX_VAL at their closing Enter.
module ascii_operand_parser #(
  parameter int WIDTH      = 5,
  parameter int MAX_DIGITS = 2,
  parameter int MAX_VAL    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic             operands_valid,
  input  logic             operands_ready,
  output logic             parse_err
);

  localparam int AW = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    GET_X     = 2'd0,
    GET_Y     = 2'd1,
    HOLD      = 2'd2,
    ERR_DRAIN = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;

  logic          is_digit;
  logic          is_enter;
  logic [AW-1:0] acc_next;
  logic          range_bad;

  // Character classification and next accumulator value
  always_comb begin
    is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
    is_enter = (char_in == 8'h0A) || (char_in == 8'h0D);
    acc_next = (acc * AW'(10)) + AW'(char_in[3:0]);
  end

`ifdef PARSER_RANGE_CHECK_EN
  assign range_bad = (acc > AW'(MAX_VAL));
`else
  // Without the range check the operand simply wraps modulo 2**WIDTH
  assign range_bad = 1'b0;
`endif

  // Parser FSM with registered handshake and error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= GET_X;
      acc            <= '0;
      cnt            <= '0;
      x_out          <= '0;
      y_out          <= '0;
      operands_valid <= 1'b0;
      char_ready     <= 1'b1;
      parse_err      <= 1'b0;
    end else begin
      parse_err <= 1'b0;
      case (state)
        GET_X, GET_Y: begin
          if (char_valid) begin
            if (is_digit) begin
              if (cnt == CW'(MAX_DIGITS)) begin
                parse_err <= 1'b1;
                state     <= ERR_DRAIN;
              end else begin
                acc <= acc_next;
                cnt <= cnt + CW'(1);
              end
            end else if (is_enter) begin
              if (cnt == '0) begin
                parse_err <= 1'b1;
                state     <= ERR_DRAIN;
              end else if (range_bad) begin
                // Enter is consumed; the whole pair restarts at X
                parse_err <= 1'b1;
                state     <= GET_X;
                acc       <= '0;
                cnt       <= '0;
              end else begin
                acc <= '0;
                cnt <= '0;
                if (state == GET_X) begin
                  x_out <= acc[WIDTH-1:0];
                  state <= GET_Y;
                end else begin
                  y_out          <= acc[WIDTH-1:0];
                  state          <= HOLD;
                  operands_valid <= 1'b1;
                  char_ready     <= 1'b0;
                end
              end
            end else begin
              parse_err <= 1'b1;
              state     <= ERR_DRAIN;
            end
          end
        end
        HOLD: begin
          if (operands_ready) begin
            operands_valid <= 1'b0;
            char_ready     <= 1'b1;
            state          <= GET_X;
          end
        end
        ERR_DRAIN: begin
          if (char_valid && is_enter) begin
            acc   <= '0;
            cnt   <= '0;
            state <= GET_X;
          end
        end
        default: state <= GET_X;
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_operand_parser.sv
// Bench for ascii_operand_parser: table vectors, directed corner sequences, randomized stream vs token model.
// Inputs change 1ns after the rising edge; outputs are compared 1ns after each edge.
// The model works on whole operand strings (digit lists) rather than a cycle-level state machine.
module tb_ascii_operand_parser;

  logic       clk;
  logic       rst_n;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [4:0] x_out;
  logic [4:0] y_out;
  logic       operands_valid;
  logic       operands_ready;
  logic       parse_err;

  ascii_operand_parser #(.WIDTH(5), .MAX_DIGITS(2), .MAX_VAL(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .char_in        (char_in),
    .char_valid     (char_valid),
    .char_ready     (char_ready),
    .x_out          (x_out),
    .y_out          (y_out),
    .operands_valid (operands_valid),
    .operands_ready (operands_ready),
    .parse_err      (parse_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PARSER_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: current operand's digits, operands completed so far, and flags
  int m_x, m_y;
  bit m_hold, m_drain, m_err;
  int m_done;
  int m_digs[$];

  typedef struct {
    logic       v;
    logic [7:0] c;
    logic       r;
    int         ex;
    int         ey;
    int         ev;
    int         ee;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_y = 0; m_hold = 0; m_drain = 0; m_err = 0; m_done = 0;
    m_digs.delete();
  endtask

  task automatic model_step(input bit v, input logic [7:0] c, input bit r);
    int val;
    m_err = 0;
    if (m_hold) begin
      if (r) m_hold = 0;
    end else if (v) begin
      if (m_drain) begin
        if (c == 8'h0A || c == 8'h0D) begin
          m_drain = 0;
          m_digs.delete();
        end
      end else if (c >= "0" && c <= "9") begin
        if (m_digs.size() == 2) begin
          m_err = 1; m_drain = 1; m_done = 0;
        end else begin
          m_digs.push_back(int'(c) - 48);
        end
      end else if (c == 8'h0A || c == 8'h0D) begin
        if (m_digs.size() == 0) begin
          m_err = 1; m_drain = 1; m_done = 0;
        end else begin
          val = 0;
          foreach (m_digs[i]) val = val * 10 + m_digs[i];
          m_digs.delete();
          if (RANGE_CHECK && val > 15) begin
            m_err = 1; m_done = 0;
          end else if (m_done == 0) begin
            m_x = val % 32; m_done = 1;
          end else begin
            m_y = val % 32; m_done = 0; m_hold = 1;
          end
        end
      end else begin
        m_err = 1; m_drain = 1; m_done = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".x_out"}, int'(x_out), m_x);
    chk({tag, ".y_out"}, int'(y_out), m_y);
    chk({tag, ".valid"}, int'(operands_valid), int'(m_hold));
    chk({tag, ".char_ready"}, int'(char_ready), int'(!m_hold));
    chk({tag, ".parse_err"}, int'(parse_err), int'(m_err));
  endtask

  // Drive one cycle, advance past the edge, update the model and compare
  task automatic step(input bit v, input logic [7:0] c, input bit r, input string tag);
    char_valid = v;
    char_in = c;
    operands_ready = r;
    @(posedge clk);
    #1;
    model_step(v, c, r);
    check_model(tag);
  endtask

  task automatic send(input string s, input bit r, input string tag);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], r, tag);
  endtask

  initial begin
    int dg;
    logic [7:0] ch;
    rst_n = 1'b0;
    char_valid = 1'b0;
    char_in = 8'h00;
    operands_ready = 1'b0;
    model_reset();
    #23;
    chk("reset.x_out", int'(x_out), 0);
    chk("reset.y_out", int'(y_out), 0);
    chk("reset.valid", int'(operands_valid), 0);
    chk("reset.char_ready", int'(char_ready), 1);
    chk("reset.parse_err", int'(parse_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic pair "12","07", then bad char in X, then pair "04","05"
    tbl.push_back('{1'b1, "1",   1'b1, 0,  0, 0, 0});
    tbl.push_back('{1'b1, "2",   1'b1, 0,  0, 0, 0});
    tbl.push_back('{1'b1, 8'h0A, 1'b1, 12, 0, 0, 0});
    tbl.push_back('{1'b1, "0",   1'b1, 12, 0, 0, 0});
    tbl.push_back('{1'b1, "7",   1'b1, 12, 0, 0, 0});
    tbl.push_back('{1'b1, 8'h0A, 1'b1, 12, 7, 1, 0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 12, 7, 0, 0});
    tbl.push_back('{1'b1, "3",   1'b1, 12, 7, 0, 0});
    tbl.push_back('{1'b1, "A",   1'b1, 12, 7, 0, 1});
    tbl.push_back('{1'b1, 8'h0A, 1'b1, 12, 7, 0, 0});
    tbl.push_back('{1'b1, "0",   1'b1, 12, 7, 0, 0});
    tbl.push_back('{1'b1, "4",   1'b1, 12, 7, 0, 0});
    tbl.push_back('{1'b1, 8'h0D, 1'b1, 4,  7, 0, 0});
    tbl.push_back('{1'b1, "0",   1'b1, 4,  7, 0, 0});
    tbl.push_back('{1'b1, "5",   1'b1, 4,  7, 0, 0});
    tbl.push_back('{1'b1, 8'h0A, 1'b1, 4,  5, 1, 0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 4,  5, 0, 0});
    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].c, tbl[i].r, "tbl");
      chk("tbl.x", int'(x_out), tbl[i].ex);
      chk("tbl.y", int'(y_out), tbl[i].ey);
      chk("tbl.valid", int'(operands_valid), tbl[i].ev);
      chk("tbl.err", int'(parse_err), tbl[i].ee);
    end

    // Held pair under backpressure: chars offered while holding are not taken
    send("15\n15\n", 1'b0, "hold");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, "9", 1'b0, "hold_wait");
      chk("hold.valid", int'(operands_valid), 1);
      chk("hold.char_ready", int'(char_ready), 0);
      chk("hold.x", int'(x_out), 15);
      chk("hold.y", int'(y_out), 15);
    end
    step(1'b0, 8'h00, 1'b1, "release");
    chk("release.valid", int'(operands_valid), 0);

    // Too many digits, then empty Enter
    send("12", 1'b1, "ovf");
    step(1'b1, "3", 1'b1, "ovf3");
    chk("ovf.err", int'(parse_err), 1);
    step(1'b1, 8'h0A, 1'b1, "drain_exit");
    chk("drain_exit.err", int'(parse_err), 0);
    step(1'b1, 8'h0A, 1'b1, "empty");
    chk("empty.err", int'(parse_err), 1);
    step(1'b1, 8'h0A, 1'b1, "drain_exit2");

    // Out-of-range operand "40"
    send("40", 1'b1, "range");
    step(1'b1, 8'h0A, 1'b1, "range_enter");
`ifdef PARSER_RANGE_CHECK_EN
    chk("range.err", int'(parse_err), 1);
    chk("range.x_kept", int'(x_out), 15);
    send("3\n", 1'b1, "range_x");
    chk("range.x_after", int'(x_out), 3);
`else
    chk("range.err", int'(parse_err), 0);
    chk("range.x_wrap", int'(x_out), 8);
`endif
    send("1\n", 1'b1, "range_y");
    chk("range.valid", int'(operands_valid), 1);
    step(1'b0, 8'h00, 1'b1, "range_rel");

    // Reset in the middle of Y entry
    send("12\n3", 1'b1, "mid");
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst.x", int'(x_out), 0);
    chk("midrst.y", int'(y_out), 0);
    chk("midrst.valid", int'(operands_valid), 0);
    chk("midrst.char_ready", int'(char_ready), 1);
    chk("midrst.err", int'(parse_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send("5\n6\n", 1'b1, "after_rst");
    chk("after_rst.x", int'(x_out), 5);
    chk("after_rst.y", int'(y_out), 6);
    chk("after_rst.valid", int'(operands_valid), 1);

    // Randomized stream against the model
    for (int i = 0; i < 3000; i++) begin
      dg = $urandom_range(0, 99);
      if (dg < 65) ch = 8'h30 + 8'($urandom_range(0, 9));
      else if (dg < 80) ch = 8'h0A;
      else if (dg < 88) ch = 8'h0D;
      else ch = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 99) < 80), ch, 1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
